// File: rtl/clock_adjust_ctrl.sv
// clock_adjust_ctrl: time-setting sequencer for the clock display.
// Captures the running time on entry, lets the user step one field at a time,
// drives per-field select/blink to the digit splitters, and hands the adjusted
// time back to the time counter with a one-cycle load pulse on exit.
module clock_adjust_ctrl #(
  parameter int BLINK_HALF = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  output logic       o_adjust,
  output logic       o_sel_sec,
  output logic       o_sel_min,
  output logic       o_sel_hour,
  output logic       o_on_off,
  output logic [4:0] o_hour,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic       o_load
);

  // A BLINK_HALF of 1 still needs a one-bit counter so the vector stays legal.
  localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADJ, S_LOAD} state_t;
  typedef enum logic [1:0] {F_SEC, F_MIN, F_HOUR} field_t;

  state_t           state, state_nxt;
  field_t           field, field_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             on_off_nxt;
  logic [4:0]       hour_nxt;
  logic [5:0]       min_nxt, sec_nxt;
  logic [5:0]       hour_ext;

  // Step up with wrap from max back to zero.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

  // Step down with wrap from zero up to max.
  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
    return (v == 6'd0 || v > max) ? max : v - 6'd1;
  endfunction

  // Next-state, field edits and blink phase; holds everything by default.
  always_comb begin
    state_nxt  = state;
    field_nxt  = field;
    cnt_nxt    = cnt;
    on_off_nxt = o_on_off;
    hour_nxt   = o_hour;
    min_nxt    = o_min;
    sec_nxt    = o_sec;
    hour_ext   = {1'b0, o_hour};
    case (state)
      S_IDLE: begin
        hour_nxt   = i_hour;
        min_nxt    = i_min;
        sec_nxt    = i_sec;
        on_off_nxt = 1'b1;
        cnt_nxt    = '0;
        if (btn_mode) begin
          state_nxt = S_ADJ;
          field_nxt = F_SEC;
        end
      end
      S_ADJ: begin
        if (btn_mode) begin
          state_nxt  = S_LOAD;
          on_off_nxt = 1'b1;
          cnt_nxt    = '0;
        end else if (btn_sel) begin
          case (field)
            F_SEC:   field_nxt = F_MIN;
            F_MIN:   field_nxt = F_HOUR;
            default: field_nxt = F_SEC;
          endcase
          on_off_nxt = 1'b1;
          cnt_nxt    = '0;
        end else if (btn_up ^ btn_down) begin
          // Exactly one direction pressed: edit the selected field.
          case (field)
            F_SEC:   sec_nxt = btn_up ? wrap_inc(o_sec, 6'd59) : wrap_dec(o_sec, 6'd59);
            F_MIN:   min_nxt = btn_up ? wrap_inc(o_min, 6'd59) : wrap_dec(o_min, 6'd59);
            default: begin
              hour_ext = btn_up ? wrap_inc({1'b0, o_hour}, 6'd23)
                                : wrap_dec({1'b0, o_hour}, 6'd23);
              hour_nxt = hour_ext[4:0];
            end
          endcase
          on_off_nxt = 1'b1;
          cnt_nxt    = '0;
        end else if (i_tick) begin
          if (cnt == CNT_LAST) begin
            cnt_nxt    = '0;
            on_off_nxt = ~o_on_off;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_LOAD: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt  = S_IDLE;
        on_off_nxt = 1'b1;
        cnt_nxt    = '0;
      end
    endcase
  end

  // State, captured time and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      field      <= F_SEC;
      cnt        <= '0;
      o_on_off   <= 1'b1;
      o_hour     <= '0;
      o_min      <= '0;
      o_sec      <= '0;
      o_adjust   <= 1'b0;
      o_load     <= 1'b0;
      o_sel_sec  <= 1'b0;
      o_sel_min  <= 1'b0;
      o_sel_hour <= 1'b0;
    end else begin
      state      <= state_nxt;
      field      <= field_nxt;
      cnt        <= cnt_nxt;
      o_on_off   <= on_off_nxt;
      o_hour     <= hour_nxt;
      o_min      <= min_nxt;
      o_sec      <= sec_nxt;
      o_adjust   <= (state_nxt == S_ADJ);
      o_load     <= (state_nxt == S_LOAD);
      o_sel_sec  <= (state_nxt == S_ADJ) && (field_nxt == F_SEC);
      o_sel_min  <= (state_nxt == S_ADJ) && (field_nxt == F_MIN);
      o_sel_hour <= (state_nxt == S_ADJ) && (field_nxt == F_HOUR);
    end
  end

endmodule
